// File: rtl/lsu_if.sv
// Load/store request/response bus between the core MEM stage and the LSU.
//   master (core): drives req, wren, funct3, addr, st_data; receives ack, fault, ld_data
//   slave  (lsu) : the reverse
interface lsu_if;
    logic        req;
    logic        wren;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        ack;
    logic        fault;
    logic [31:0] ld_data;

    modport master (output req, wren, funct3, addr, st_data,
                    input  ack, fault, ld_data);
    modport slave  (input  req, wren, funct3, addr, st_data,
                    output ack, fault, ld_data);
endinterface

// File: rtl/lsu_pipelined_io.sv
// Pipelined RV32I load/store unit with data memory and memory-mapped board I/O.
// One request per cycle, registered response one cycle later, no stalls.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : lsu_if slave (request in, ack/fault/ld_data out)
//   io_sw, io_btn  : raw asynchronous switches / buttons (synchronised here)
//   io_ledr/ledg   : LED registers; io_hex: NUM_HEX packed 7-seg digits; io_lcd: LCD register
module lsu_pipelined_io #(
    parameter int unsigned DMEM_AW     = 11,
    parameter int unsigned NUM_HEX     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned BTN_W       = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    lsu_if.slave                 bus,
    input  logic [31:0]          io_sw,
    input  logic [BTN_W-1:0]     io_btn,
    output logic [31:0]          io_ledr,
    output logic [31:0]          io_ledg,
    output logic [7*NUM_HEX-1:0] io_hex,
    output logic [31:0]          io_lcd
);
    localparam int unsigned DMEM_WORDS = 1 << DMEM_AW;
    localparam logic [15:0] A_LEDR = 16'h7000;
    localparam logic [15:0] A_LEDG = 16'h7010;
    localparam logic [15:0] A_HEX0 = 16'h7020;
    localparam logic [15:0] A_HEX1 = 16'h7024;
    localparam logic [15:0] A_LCD  = 16'h7030;
    localparam logic [15:0] A_SW   = 16'h7800;
    localparam logic [15:0] A_BTNL = 16'h7804;
    localparam logic [15:0] A_BTNE = 16'h7808;

    logic [15:0]        a;
    logic [15:0]        wa;
    logic [1:0]         off;
    logic [DMEM_AW-1:0] idx;
    logic               hit_dmem, hit_ledr, hit_ledg, hit_hex0, hit_hex1, hit_lcd;
    logic               hit_sw, hit_btnl, hit_btne;
    logic               legal, misalign, fault_c, wr_en, clr;
    logic [3:0]         be;
    logic [31:0]        wdata, rword, sh, ext;
    logic               unused_addr_hi;

    logic [31:0]        mem [DMEM_WORDS];
    logic [31:0]        sw_sync  [SYNC_STAGES];
    logic [BTN_W-1:0]   btn_sync [SYNC_STAGES];
    logic [BTN_W-1:0]   btn_q, btn_latch;

    // Only the low half-word of the address is decoded; the rest aliases.
    assign a              = bus.addr[15:0];
    assign unused_addr_hi = ^bus.addr[31:16];
    assign wa             = {a[15:2], 2'b00};
    assign off            = a[1:0];
    assign idx            = bus.addr[DMEM_AW+1:2];

    assign hit_dmem = (a[15:13] == 3'b001);
    assign hit_ledr = (wa == A_LEDR);
    assign hit_ledg = (wa == A_LEDG);
    assign hit_hex0 = (wa == A_HEX0);
    assign hit_hex1 = (wa == A_HEX1);
    assign hit_lcd  = (wa == A_LCD);
    assign hit_sw   = (wa == A_SW);
    assign hit_btnl = (wa == A_BTNL);
    assign hit_btne = (wa == A_BTNE);

    // funct3 legality and alignment
    always_comb begin
        legal    = 1'b0;
        misalign = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: begin legal = 1'b1; misalign = off[0]; end
            3'b010:         begin legal = 1'b1; misalign = |off;   end
            default:        legal = 1'b0;
        endcase
    end

    assign fault_c = ~legal | misalign;
    assign wr_en   = bus.req & bus.wren & ~fault_c;
    assign clr     = bus.req & ~bus.wren & ~fault_c & hit_btne;

    // Byte enables and lane-replicated store data
    always_comb begin
        be    = 4'b1111;
        wdata = bus.st_data;
        case (bus.funct3[1:0])
            2'b00: begin be = 4'(4'b0001 << off); wdata = {4{bus.st_data[7:0]}};  end
            2'b01: begin be = 4'(4'b0011 << off); wdata = {2{bus.st_data[15:0]}}; end
            default: ;
        endcase
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] en);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = en[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // Data memory: not reset; writes suppressed while reset is held
    always_ff @(posedge i_clk) begin
        if (wr_en && i_rst_n && hit_dmem) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Output registers; each HEX byte lane k carries the 7-bit digit k
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            io_ledr <= '0;
            io_ledg <= '0;
            io_lcd  <= '0;
            io_hex  <= '0;
        end else if (wr_en) begin
            if (hit_ledr) io_ledr <= merge(io_ledr, wdata, be);
            if (hit_ledg) io_ledg <= merge(io_ledg, wdata, be);
            if (hit_lcd)  io_lcd  <= merge(io_lcd, wdata, be);
            for (int k = 0; k < int'(NUM_HEX); k++) begin
                if (((k < 4) ? hit_hex0 : hit_hex1) && be[2'(k)])
                    io_hex[7*k +: 7] <= wdata[8*(k % 4) +: 7];
            end
        end
    end

    // Input synchronisers and button rising-edge latch (set beats clear)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sw_sync[s]  <= '0;
                btn_sync[s] <= '0;
            end
            btn_q     <= '0;
            btn_latch <= '0;
        end else begin
            sw_sync[0]  <= io_sw;
            btn_sync[0] <= io_btn;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sw_sync[s]  <= sw_sync[s-1];
                btn_sync[s] <= btn_sync[s-1];
            end
            btn_q     <= btn_sync[SYNC_STAGES-1];
            btn_latch <= (btn_latch & ~{BTN_W{clr}}) | (btn_sync[SYNC_STAGES-1] & ~btn_q);
        end
    end

    // Read word mux; unmapped addresses and absent digits read as zero
    always_comb begin
        rword = '0;
        if (hit_dmem)      rword = mem[idx];
        else if (hit_ledr) rword = io_ledr;
        else if (hit_ledg) rword = io_ledg;
        else if (hit_lcd)  rword = io_lcd;
        else if (hit_sw)   rword = sw_sync[SYNC_STAGES-1];
        else if (hit_btnl) rword = 32'(btn_sync[SYNC_STAGES-1]);
        else if (hit_btne) rword = 32'(btn_latch);
        else if (hit_hex0 || hit_hex1) begin
            for (int b = 0; b < 4; b++) begin
                if (hit_hex1) begin
                    if (b + 4 < int'(NUM_HEX)) rword[8*b +: 7] = io_hex[7*(b+4) +: 7];
                end else if (b < int'(NUM_HEX)) begin
                    rword[8*b +: 7] = io_hex[7*b +: 7];
                end
            end
        end
    end

    // Lane select and sign/zero extension
    always_comb begin
        sh = rword >> {off, 3'b000};
        case (bus.funct3)
            3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ext = {24'h0, sh[7:0]};
            3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ext = {16'h0, sh[15:0]};
            default: ext = rword;
        endcase
    end

    // Registered response; ld_data holds between load acks
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.ack     <= 1'b0;
            bus.fault   <= 1'b0;
            bus.ld_data <= '0;
        end else begin
            bus.ack   <= bus.req;
            bus.fault <= bus.req & fault_c;
            if (bus.req) begin
                if (fault_c)        bus.ld_data <= '0;
                else if (!bus.wren) bus.ld_data <= ext;
            end
        end
    end
endmodule

// File: tb/tb_lsu_pipelined_io.sv
module tb_lsu_pipelined_io;
    localparam int unsigned NUM_HEX     = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned BTN_W       = 4;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;
    localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101;

    typedef struct {
        logic        fault;
        logic        chk;
        logic [31:0] data;
        int          id;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [31:0]          io_sw;
    logic [BTN_W-1:0]     io_btn;
    logic [31:0]          io_ledr, io_ledg, io_lcd;
    logic [7*NUM_HEX-1:0] io_hex;

    int   checks = 0;
    int   errors = 0;
    int   n_ops  = 0;
    exp_t sb[$];

    lsu_if bus();

    lsu_pipelined_io #(
        .DMEM_AW(11), .NUM_HEX(NUM_HEX), .SYNC_STAGES(SYNC_STAGES), .BTN_W(BTN_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
        .io_sw(io_sw), .io_btn(io_btn),
        .io_ledr(io_ledr), .io_ledg(io_ledg), .io_hex(io_hex), .io_lcd(io_lcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic ef, input logic ck, input logic [31:0] ed);
        exp_t e;
        @(negedge clk);
        bus.req = 1'b1; bus.wren = wr; bus.funct3 = f3; bus.addr = a; bus.st_data = d;
        e.fault = ef; e.chk = ck; e.data = ed; e.id = n_ops;
        sb.push_back(e);
        n_ops++;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] ed);
        op(1'b0, f3, a, 32'h0, 1'b0, 1'b1, ed);
    endtask
    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        op(1'b1, f3, a, d, 1'b0, 1'b0, 32'h0);
    endtask
    task automatic ldf(input logic [2:0] f3, input logic [31:0] a);
        op(1'b0, f3, a, 32'h0, 1'b1, 1'b1, 32'h0);
    endtask
    task automatic stf(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        op(1'b1, f3, a, d, 1'b1, 1'b1, 32'h0);
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
    endtask

    // Response monitor: ack must follow each accepted request by exactly one cycle
    always @(posedge clk) begin : mon
        logic acc;
        exp_t e;
        acc = bus.req && rst_n;
        #1;
        chk("ack", 32'(bus.ack), 32'(acc));
        if (acc) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("fault#%0d", e.id), 32'(bus.fault), 32'(e.fault));
                if (e.chk) chk($sformatf("ld_data#%0d", e.id), bus.ld_data, e.data);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.req = 1'b0; bus.wren = 1'b0; bus.funct3 = 3'b0; bus.addr = '0; bus.st_data = '0;
        io_sw = '0; io_btn = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_fault", 32'(bus.fault), 32'h0);
        chk("rst_ld_data", bus.ld_data, 32'h0);
        chk("rst_ledr", io_ledr, 32'h0);
        chk("rst_ledg", io_ledg, 32'h0);
        chk("rst_lcd", io_lcd, 32'h0);
        chk("rst_hex_lo", io_hex[31:0], 32'h0);
        chk("rst_hex_hi", 32'(io_hex[55:32]), 32'h0);
        rst_n = 1'b1;

        // Extension of byte/half loads, back-to-back after the store
        st(F_W, 32'h2004, 32'h8081_82F3);
        ld(F_B, 32'h2004, 32'hFFFF_FFF3);
        ld(F_BU, 32'h2007, 32'h0000_0080);
        ld(F_H, 32'h2006, 32'hFFFF_8081);
        ld(F_HU, 32'h2006, 32'h0000_8081);
        ld(F_B, 32'h2005, 32'hFFFF_FF82);
        ld(F_BU, 32'h2005, 32'h0000_0082);

        // Byte/half stores merge into the word; load right after sees new data
        st(F_W, 32'h2004, 32'h1122_3344);
        st(F_B, 32'h2005, 32'hDEAD_BEAA);
        ld(F_W, 32'h2004, 32'h1122_AA44);
        st(F_H, 32'h2006, 32'h9999_5566);
        ld(F_W, 32'h2004, 32'h5566_AA44);
        ld(F_W, 32'h0001_2004, 32'h5566_AA44);

        // Faults: misaligned, illegal funct3; no write happens
        ldf(F_W, 32'h2002);
        ldf(F_H, 32'h2001);
        stf(F_W, 32'h2001, 32'hFFFF_FFFF);
        stf(3'b110, 32'h2004, 32'hFFFF_FFFF);
        ldf(3'b011, 32'h2004);
        ld(F_W, 32'h2004, 32'h5566_AA44);

        // HEX, LED and LCD registers
        st(F_W, 32'h7020, 32'h4079_2440);
        st(F_B, 32'h7025, 32'h1234_567F);
        st(F_W, 32'h7000, 32'hCAFE_BABE);
        st(F_B, 32'h7002, 32'h0000_0011);
        st(F_W, 32'h7010, 32'h1234_5678);
        st(F_H, 32'h7032, 32'h0000_BEEF);
        idle(1);
        chk("hex_d0", 32'(io_hex[6:0]), 32'h40);
        chk("hex_d1", 32'(io_hex[13:7]), 32'h24);
        chk("hex_d2", 32'(io_hex[20:14]), 32'h79);
        chk("hex_d3", 32'(io_hex[27:21]), 32'h40);
        chk("hex_d5", 32'(io_hex[41:35]), 32'h7F);
        chk("ledr", io_ledr, 32'hCA11_BABE);
        chk("ledg", io_ledg, 32'h1234_5678);
        chk("lcd", io_lcd, 32'hBEEF_0000);
        ld(F_W, 32'h7020, 32'h4079_2440);
        ld(F_W, 32'h7024, 32'h0000_7F00);
        ld(F_W, 32'h7000, 32'hCA11_BABE);
        ld(F_BU, 32'h7033, 32'h0000_00BE);

        // Unmapped address: zero, no fault, store ignored
        ld(F_W, 32'h5000, 32'h0);
        st(F_W, 32'h5000, 32'hFFFF_FFFF);
        ld(F_W, 32'h5000, 32'h0);
        ld(F_W, 32'h4000, 32'h0);

        // Button edge latch
        @(negedge clk); bus.req = 1'b0; io_btn = 4'h4;
        idle(3);
        ld(F_W, 32'h7804, 32'h4);
        @(negedge clk); bus.req = 1'b0; io_btn = 4'h0;
        idle(4);
        ld(F_W, 32'h7808, 32'h4);
        ld(F_W, 32'h7808, 32'h0);
        // Edge lands on the same cycle as the clearing read: bit survives
        @(negedge clk); bus.req = 1'b0; io_btn = 4'h4;
        @(negedge clk); bus.req = 1'b0;
        ld(F_W, 32'h7808, 32'h0);
        ld(F_W, 32'h7808, 32'h4);
        ld(F_W, 32'h7808, 32'h0);

        // Switch synchroniser latency
        @(negedge clk); bus.req = 1'b0; io_sw = 32'h5A;
        idle(2);
        ld(F_W, 32'h7800, 32'h5A);
        @(negedge clk); bus.req = 1'b0; io_sw = 32'hA5;
        ld(F_W, 32'h7800, 32'h5A);
        idle(2);
        ld(F_W, 32'h7800, 32'hA5);

        // Reset arriving with a store in flight
        st(F_W, 32'h2010, 32'h0BAD_F00D);
        @(negedge clk);
        bus.req = 1'b1; bus.wren = 1'b1; bus.funct3 = F_W;
        bus.addr = 32'h2010; bus.st_data = 32'h1234_5678;
        rst_n = 1'b0;
        @(negedge clk); bus.req = 1'b0;
        chk("midrst_ack", 32'(bus.ack), 32'h0);
        chk("midrst_ledr", io_ledr, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        ld(F_W, 32'h2010, 32'h0BAD_F00D);
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
